// File: rtl/comms_pkg.sv
// Shared definitions for the single-wire op link.
//   op          : 4-bit op code type
//   OP_BITS     : data bits per frame
//   tx_state_t  : transmitter FSM states
//   LINE_IDLE / START_BIT : serial line levels
package comms_pkg;

  typedef logic [3:0] op;

  localparam int unsigned OP_BITS = 4;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } tx_state_t;

  localparam logic LINE_IDLE = 1'b0;
  localparam logic START_BIT = 1'b1;

endpackage

// File: rtl/op_fifo.sv
// Synchronous circular FIFO of op codes. Pointers carry one extra wrap bit so that
// full and empty are distinguishable without a separate count.
// Ports:
//   clk_in, rst_n_in : clock, asynchronous active-low reset (empties the FIFO)
//   push, wdata      : write strobe and data (caller guarantees !full)
//   pop, rdata       : read strobe and head-of-queue data (valid when !empty)
//   full, empty      : status flags
module op_fifo
  import comms_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic push,
  input  op    wdata,
  input  logic pop,
  output op    rdata,
  output logic full,
  output logic empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0] wr_ptr_q, rd_ptr_q;
  op           mem_q [DEPTH];

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage needs no reset: entries are only read once the pointers say they were written.
  always_ff @(posedge clk_in) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/op_tx.sv
// Serial transmitter for 4-bit op codes. Frame: high start bit, four data bits LSB
// first, low stop bit, each CLK_BAUD_RATIO clocks long. Line idles low.
// Optional feature macro: OP_TX_FIFO_EN adds a FIFO_DEPTH-entry input FIFO.
// Ports:
//   clk_in        : clock
//   rst_n_in      : asynchronous active-low reset (drops any frame, forces line low)
//   op_in         : op code to send
//   op_valid_in   : op_in valid
//   op_ready_out  : op_in accepted on a rising edge when valid && ready
//   tx_out        : serial line (registered)
//   busy_out      : frame in progress
module op_tx
  import comms_pkg::*;
#(
  parameter int unsigned CLK_BAUD_RATIO = 8,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  op    op_in,
  input  logic op_valid_in,
  output logic op_ready_out,
  output logic tx_out,
  output logic busy_out
);

  localparam int unsigned CntW = $clog2(CLK_BAUD_RATIO);
  localparam logic [CntW-1:0] CntLast = CntW'(CLK_BAUD_RATIO - 1);
  localparam logic [1:0] IdxLast = 2'(OP_BITS - 1);

  if (CLK_BAUD_RATIO < 2 || FIFO_DEPTH < 2) begin : g_bad_param
    $error("op_tx: CLK_BAUD_RATIO and FIFO_DEPTH must both be >= 2");
  end

  tx_state_t       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  op               shift_q, shift_d;
  logic            tx_q, tx_d;
  logic            bit_end;
  logic            start_req;
  op               start_op;

`ifdef OP_TX_FIFO_EN
  logic fifo_full, fifo_empty, fifo_push, fifo_pop;
  op    fifo_rdata;

  assign fifo_push    = op_valid_in && !fifo_full;
  // The pop edge is the IDLE->START edge, hence the extra cycle of latency.
  assign fifo_pop     = (state_q == StIdle) && !fifo_empty;
  assign op_ready_out = !fifo_full;
  assign start_req    = !fifo_empty;
  assign start_op     = fifo_rdata;

  op_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_in  (clk_in),
    .rst_n_in(rst_n_in),
    .push    (fifo_push),
    .wdata   (op_in),
    .pop     (fifo_pop),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );
`else
  assign op_ready_out = (state_q == StIdle);
  assign start_req    = op_valid_in;
  assign start_op     = op_in;
`endif

  assign bit_end  = (cnt_q == CntLast);
  assign busy_out = (state_q != StIdle);
  assign tx_out   = tx_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = bit_end ? '0 : cnt_q + 1'b1;
    idx_d   = idx_q;
    shift_d = shift_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        idx_d = '0;
        if (start_req) begin
          state_d = StStart;
          shift_d = start_op;
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d = StData;
          idx_d   = '0;
        end
      end
      StData: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          idx_d   = idx_q + 2'd1;
          if (idx_q == IdxLast) state_d = StStop;
        end
      end
      StStop: begin
        if (bit_end) state_d = StIdle;
      end
    endcase
  end

  // Line level is a function of the next state so the flop presents it exactly
  // in the cycles that state occupies.
  always_comb begin
    tx_d = LINE_IDLE;
    case (state_d)
      StStart: tx_d = START_BIT;
      StData:  tx_d = shift_d[0];
      default: tx_d = LINE_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= LINE_IDLE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: tb/tb_op_tx.sv
module tb_op_tx;

  localparam int R  = 8;
  localparam int R2 = 2;
`ifdef OP_TX_FIFO_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic       clk_in = 1'b0;
  logic       rst_n_in = 1'b0;
  logic [3:0] op_in = 4'h0;
  logic       op_valid_in = 1'b0;
  logic       op_ready_out, tx_out, busy_out;
  logic [3:0] op2 = 4'h0;
  logic       valid2 = 1'b0;
  logic       ready2, tx2, busy2;

  int checks = 0;
  int passed = 0;

  always #5 clk_in = ~clk_in;

  op_tx #(
    .CLK_BAUD_RATIO(R),
    .FIFO_DEPTH    (4)
  ) dut (
    .clk_in      (clk_in),
    .rst_n_in    (rst_n_in),
    .op_in       (op_in),
    .op_valid_in (op_valid_in),
    .op_ready_out(op_ready_out),
    .tx_out      (tx_out),
    .busy_out    (busy_out)
  );

  op_tx #(
    .CLK_BAUD_RATIO(R2),
    .FIFO_DEPTH    (4)
  ) dut2 (
    .clk_in      (clk_in),
    .rst_n_in    (rst_n_in),
    .op_in       (op2),
    .op_valid_in (valid2),
    .op_ready_out(ready2),
    .tx_out      (tx2),
    .busy_out    (busy2)
  );

  // j = cycles after the IDLE->START edge (j=1 is the first start-bit cycle).
  function automatic logic exp_tx(input logic [3:0] v, input int j, input int r);
    if (j >= 1 && j <= r) return 1'b1;
    if (j > r && j <= 5 * r) return v[(j - r - 1) / r];
    return 1'b0;
  endfunction

  function automatic logic exp_busy(input int j, input int r);
    return (j >= 1 && j <= 6 * r);
  endfunction

  // Each iteration advances one clock; the first posedge yields cycle first_j.
  task automatic frame_check(input logic [3:0] v, input int first_j, input bit drop,
                             input string tag);
    logic [3:0] rx;
    rx = 4'h0;
    for (int j = first_j; j <= 6 * R; j++) begin
      @(posedge clk_in); #1;
      if (drop && j >= 1 - LAT) op_valid_in = 1'b0;
      checks++;
      if (tx_out !== exp_tx(v, j, R)) $display("FAIL %s tx j=%0d: got %b want %b",
                                               tag, j, tx_out, exp_tx(v, j, R));
      else passed++;
      checks++;
      if (busy_out !== exp_busy(j, R)) $display("FAIL %s busy j=%0d: got %b want %b",
                                                tag, j, busy_out, exp_busy(j, R));
      else passed++;
`ifndef OP_TX_FIFO_EN
      checks++;
      if (op_ready_out !== !exp_busy(j, R)) $display("FAIL %s ready j=%0d: got %b want %b",
                                                     tag, j, op_ready_out, !exp_busy(j, R));
      else passed++;
`endif
      for (int k = 0; k < 4; k++) if (j == R * (k + 1) + R / 2) rx[k] = tx_out;
    end
    checks++;
    if (rx !== v) $display("FAIL %s rx: got %b want %b", tag, rx, v);
    else passed++;
  endtask

  task automatic test_reset();
    rst_n_in = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    checks++;
    if ({tx_out, busy_out, op_ready_out} !== 3'b001)
      $display("FAIL reset_state: got %b want 001", {tx_out, busy_out, op_ready_out});
    else passed++;
    rst_n_in = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk_in); #1;
      checks++;
      if ({tx_out, busy_out, op_ready_out, tx2, busy2, ready2} !== 6'b001001)
        $display("FAIL idle cyc=%0d: got %b want 001001", i,
                 {tx_out, busy_out, op_ready_out, tx2, busy2, ready2});
      else passed++;
    end
  endtask

  task automatic test_send();
    op_in = 4'b1011;
    op_valid_in = 1'b1;
    frame_check(4'b1011, 1 - LAT, 1'b1, "send1011");
    @(posedge clk_in); #1;
    checks++;
    if ({op_ready_out, tx_out, busy_out} !== 3'b100)
      $display("FAIL send_after: got %b want 100", {op_ready_out, tx_out, busy_out});
    else passed++;
  endtask

`ifndef OP_TX_FIFO_EN
  task automatic test_hold_valid();
    op_in = 4'b1011;
    op_valid_in = 1'b1;
    @(posedge clk_in); #1;
    op_in = 4'b0110;
    frame_check(4'b1011, 2, 1'b0, "holdA");
    frame_check(4'b0110, 0, 1'b1, "holdB");
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_in); #1;
      checks++;
      if ({tx_out, busy_out} !== 2'b00)
        $display("FAIL hold_idle cyc=%0d: got %b want 00", i, {tx_out, busy_out});
      else passed++;
    end
  endtask
`endif

`ifdef OP_TX_FIFO_EN
  task automatic test_fifo();
    for (int k = 0; k < 5; k++) begin
      op_in = 4'(k + 1);
      op_valid_in = 1'b1;
      checks++;
      if (op_ready_out !== 1'b1) $display("FAIL fifo_ready push=%0d: got %b want 1",
                                          k, op_ready_out);
      else passed++;
      @(posedge clk_in); #1;
      checks++;
      if (tx_out !== exp_tx(4'h1, k, R)) $display("FAIL fifo_early tx j=%0d: got %b want %b",
                                                  k, tx_out, exp_tx(4'h1, k, R));
      else passed++;
    end
    op_valid_in = 1'b0;
    checks++;
    if (op_ready_out !== 1'b0) $display("FAIL fifo_full ready: got %b want 0", op_ready_out);
    else passed++;
    frame_check(4'h1, 5, 1'b0, "fifo1");
    frame_check(4'h2, 0, 1'b0, "fifo2");
    frame_check(4'h3, 0, 1'b0, "fifo3");
    frame_check(4'h4, 0, 1'b0, "fifo4");
    frame_check(4'h5, 0, 1'b0, "fifo5");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_in); #1;
      checks++;
      if ({tx_out, busy_out, op_ready_out} !== 3'b001)
        $display("FAIL fifo_drain cyc=%0d: got %b want 001", i,
                 {tx_out, busy_out, op_ready_out});
      else passed++;
    end
  endtask
`endif

  task automatic test_reset_mid();
    op_in = 4'b1011;
    op_valid_in = 1'b1;
    @(posedge clk_in); #1;
`ifdef OP_TX_FIFO_EN
    op_in = 4'b0011;
    @(posedge clk_in); #1;
    op_in = 4'b0101;
    @(posedge clk_in); #1;
`endif
    op_valid_in = 1'b0;
    repeat (R + 3) @(posedge clk_in);
    #1;
    checks++;
    if ({tx_out, busy_out} !== 2'b11)
      $display("FAIL mid_data: got %b want 11", {tx_out, busy_out});
    else passed++;
    #2 rst_n_in = 1'b0;
    #1;
    checks++;
    if ({tx_out, busy_out, op_ready_out} !== 3'b001)
      $display("FAIL async_reset: got %b want 001", {tx_out, busy_out, op_ready_out});
    else passed++;
    repeat (2) @(posedge clk_in);
    #1 rst_n_in = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk_in); #1;
      checks++;
      if ({tx_out, busy_out, op_ready_out} !== 3'b001)
        $display("FAIL post_reset cyc=%0d: got %b want 001", i,
                 {tx_out, busy_out, op_ready_out});
      else passed++;
    end
  endtask

  task automatic test_r2();
    logic [3:0] vecs [2];
    vecs[0] = 4'b0000;
    vecs[1] = 4'b0110;
    for (int n = 0; n < 2; n++) begin
      op2 = vecs[n];
      valid2 = 1'b1;
      for (int j = 1 - LAT; j <= 6 * R2 + 1; j++) begin
        @(posedge clk_in); #1;
        valid2 = 1'b0;
        checks++;
        if ({tx2, busy2} !== {exp_tx(vecs[n], j, R2), exp_busy(j, R2)})
          $display("FAIL r2 v=%b j=%0d: got %b want %b", vecs[n], j, {tx2, busy2},
                   {exp_tx(vecs[n], j, R2), exp_busy(j, R2)});
        else passed++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_send();
`ifndef OP_TX_FIFO_EN
    test_hold_valid();
`else
    test_fifo();
`endif
    test_reset_mid();
    test_r2();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/op_tx.md
# op_tx

Serial transmitter for 4-bit op codes: the sending end of the single-wire op link whose receiver samples one bit per baud period. It accepts an op code over a valid/ready handshake and serialises it as a high start bit, four data bits LSB first, and a low stop bit. It sits on the host/controller side of the comms path and drives the wire that feeds the op receiver's `tx_in`.

## Interface
- `CLK_BAUD_RATIO`, 8: clock cycles per bit period; must be ≥2.
- `FIFO_DEPTH`, 4: entries in the optional input FIFO; power of two ≥2; ignored without `OP_TX_FIFO_EN`.
- `clk_in` input 1: single clock.
- `rst_n_in` input 1: reset; asynchronous, active-low.
- `op_in` input 4 (`op`): op code to send.
- `op_valid_in` input 1: `op_in` valid.
- `op_ready_out` output 1: block accepts `op_in` this cycle; transfer on `op_valid_in && op_ready_out` at a rising edge.
- `tx_out` output 1: serial line; idle low.
- `busy_out` output 1: frame in progress (state ≠ IDLE).

## Operation
- Reset values: `tx_out`=0, `busy_out`=0, `op_ready_out`=1. State=IDLE, baud counter=0, bit index=0, shift register=0. With the FIFO, it is emptied.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE→START: on accept, or on FIFO non-empty. Latches the op into the shift register and clears the baud counter.
  - START: `tx_out`=1 for R cycles, then →DATA with bit index 0.
  - DATA: `tx_out`=shift[0] for R cycles per bit. At the end of each bit, shift right and increment the index. After index 3 completes, →STOP.
  - STOP: `tx_out`=0 for R cycles, then →IDLE.
- R = `CLK_BAUD_RATIO`. The baud counter counts 0..R-1 and wraps. Its width is `$clog2(CLK_BAUD_RATIO)`. A bit boundary occurs when the counter equals R-1.
- Without the FIFO, `op_ready_out` = (state==IDLE). `op_in` is ignored when ready is low.
- `tx_out` is driven from a flop, so it is glitch-free.
- Reset asserted mid-frame: `tx_out` goes low immediately (asynchronously) and the frame is dropped. No partial frame resumes after deassertion.

## Timing
- Accept at edge N: `tx_out`=1 in cycles N+1..N+R.
- Data bit k is driven in cycles N+1+R(1+k) .. N+R(2+k).
- Stop bit is driven in cycles N+1+5R .. N+6R.
- IDLE is re-entered at edge N+6R. The next accept is possible at edge N+6R+1.
- Frame length is 6R cycles. Minimum accept-to-accept spacing is 6R+1 cycles (no FIFO).
- `busy_out` is high in cycles N+1..N+6R.

## Configuration
- `OP_TX_FIFO_EN` defined: a FIFO of `FIFO_DEPTH` entries sits between the handshake and the FSM, with `op_ready_out` = !full.
  - The FSM pops in IDLE when the FIFO is non-empty, which adds one cycle: accept at N into an empty idle block gives the start bit from N+2.
  - Push and pop in the same cycle are both honoured; the count is unchanged.
  - Push when full is impossible because ready is low.
  - Queued frames go out back-to-back with one IDLE cycle between them.
- `OP_TX_FIFO_EN` undefined: direct handshake exactly as in Operation. `FIFO_DEPTH` is unused and no FIFO storage is synthesised.

## Structure
- Shared `comms_pkg` holds:
  - `typedef logic [3:0] op`
  - `OP_BITS`=4
  - the FSM state enum `tx_state_t`
  - line constants `LINE_IDLE`=0 and `START_BIT`=1
- Sub-module `op_fifo`: synchronous circular FIFO with `push`/`pop`/`full`/`empty`, pointers one bit wider than the address. It is instantiated only under `OP_TX_FIFO_EN`.

## Test plan
- Reset then idle, R=8: `tx_out`=0, `op_ready_out`=1, `busy_out`=0 for 100 cycles.
- Send `op_in`=4'b1011 at edge N: `tx_out` is 1 for 8 cycles (start), then 1,1,0,1 at 8 cycles each, then 0 for 8 cycles. `op_ready_out` returns high at N+49. A paired op receiver model outputs 4'b1011.
- Hold `op_valid_in` high with a new value during a frame: no accept until IDLE. Exactly one frame per accept; the second frame's start bit begins at N+50.
- Assert `rst_n_in` low asynchronously mid-DATA: `tx_out`=0 in the same cycle. After release the line stays idle and ready is high. With the FIFO, queued ops are discarded.
- `OP_TX_FIFO_EN`, DEPTH=4: push 4'h1, 4'h2, 4'h3, 4'h4, 4'h5 on consecutive cycles.
  - `op_ready_out` drops only when the FIFO is full.
  - Five frames are emitted in order, each 48 cycles, separated by one idle cycle.
- R=2 corner: send 4'b0000 → `tx_out` = 1,1 then eight 0s then 0,0. Total frame 12 cycles.
